updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running counter.
- Provides configurable width and modulus, up/down counting, and count enable.
- Also provides synchronous clear, parallel load, a wrap-or-saturate boundary mode, a terminal-count pulse and a sticky overflow flag.
- Intended as the general-purpose event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 8: bit width of count register and load value.
- MAX_VAL, 255: highest count value; the counting range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
- SATURATE, 0: boundary mode. 0 = wrap (MAX_VAL->0 up, 0->MAX_VAL down). 1 = hold at the boundary.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value for load
- en  input  1  count enable
- up_dn  input  1  direction: 1 = up, 0 = down
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle)
- ovf  output  1  sticky boundary-event flag (registered)
- at_max  output  1  combinational: q == MAX_VAL
- at_zero  output  1  combinational: q == 0

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high, port name reset. When reset asserts, q=0, tc=0, ovf=0 immediately, without waiting for a clock edge. The block resumes on the first rising edge after deassertion.
- Per-edge priority: clr > load > en. Inputs are sampled at the rising edge; results are visible the same edge (latency 1 cycle).
- clr=1:
  - q <= 0, tc <= 0, ovf <= 0.
  - load and en are ignored.
- load=1 (clr=0):
  - q <= load_val. If load_val > MAX_VAL, q <= MAX_VAL (clamped).
  - tc <= 0; ovf unchanged.
  - en is ignored.
- en=1 with up_dn=1 (no clr/load):
  - q < MAX_VAL: q <= q+1, tc <= 0.
  - q == MAX_VAL: boundary event.
- en=1 with up_dn=0 (no clr/load):
  - q > 0: q <= q-1, tc <= 0.
  - q == 0: boundary event.
- Boundary event:
  - tc <= 1 for exactly one cycle. ovf <= 1, and stays set until clr or reset.
  - SATURATE=0: q wraps. Up: MAX_VAL->0. Down: 0->MAX_VAL.
  - SATURATE=1: q holds its value. tc still pulses on every enabled boundary cycle, so it stays high continuously while en is held at the boundary.
- en=0 (no clr/load): q holds, tc <= 0, ovf holds.
- Direction change takes effect on the same edge it is sampled; up_dn has no internal pipelining.
- Arithmetic:
  - All compare and increment operations are WIDTH bits, unsigned.
  - Non-power-of-two MAX_VAL must never produce values above MAX_VAL. This applies to wrap, load clamping and reset.
- Flags: at_max and at_zero are pure decodes of q. When MAX_VAL is reached they assert in the same cycle as q.
- Reset mid-count: all state is lost. After reset the count restarts at 0 and ovf is 0.

Test Plan:
- Reset/clear: hold reset 20 ns, then en=1 up_dn=1 for 5 cycles -> q=5, tc=0, ovf=0. Assert reset asynchronously mid-cycle -> q=0 before the next edge. Later, clr=1 for one cycle -> q=0, ovf=0.
- Wrap up, MAX_VAL=9, SATURATE=0: count up from 0 -> q=0..9, then 0. tc=1 only in the cycle q shows 0 after 9. ovf=1 thereafter; at_max=1 while q=9.
- Wrap down, MAX_VAL=9: load 2, then count down -> q=2,1,0,9,8. tc pulses once, coincident with q=9.
- Saturate, MAX_VAL=9, SATURATE=1: count up from 7 for 5 cycles -> q=8,9,9,9,9. tc=1 on the last three edges; ovf=1.
- Load/priority, WIDTH=8, MAX_VAL=200:
  - load_val=250 -> q=200 (clamped).
  - clr=1, load=1, en=1 together -> q=0.
  - load=1, en=1, load_val=17 -> q=17 (load wins over count).
- Enable gating: en=0 for 10 cycles with up_dn toggling -> q is constant and tc stays 0. Then en=1, up_dn=0 from q=0 with SATURATE=0 -> q=MAX_VAL and tc=1.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter: synchronous clear, clamped parallel load,
// wrap-or-saturate boundary handling, one-cycle terminal-count pulse, sticky overflow.
module updown_mod_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 255,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
   localparam logic             SAT   = (SATURATE != 0);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q,  tc_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   // Priority clr > load > en; a boundary event either wraps or holds the count.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (cnt_q == MAX_W) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
               cnt_d = SAT ? cnt_q : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (cnt_q == '0) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
               cnt_d = SAT ? cnt_q : MAX_W;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   assign q       = cnt_q;
   assign tc      = tc_q;
   assign ovf     = ovf_q;
   assign at_max  = (cnt_q == MAX_W);
   assign at_zero = (cnt_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (wrap mod-10, saturate mod-10,
// wrap 0..200) driven by shared inputs and checked against an integer model.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr, load, en, up_dn;
   logic [7:0] load_val;

   logic [3:0] q_w9, q_s9;
   logic [7:0] q_w200;
   logic tc_w9, ovf_w9, am_w9, az_w9;
   logic tc_s9, ovf_s9, am_s9, az_s9;
   logic tc_w200, ovf_w200, am_w200, az_w200;

   int n_cmp = 0;
   int n_mis = 0;

   // Model state: index 0 = wrap mod-10, 1 = saturate mod-10, 2 = wrap 0..200
   int m_q[3], m_tc[3], m_ovf[3];
   int m_max[3]  = '{9, 9, 200};
   int m_sat[3]  = '{0, 1, 0};
   int m_mask[3] = '{15, 15, 255};

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_w9 (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]),
      .en(en), .up_dn(up_dn), .q(q_w9), .tc(tc_w9), .ovf(ovf_w9),
      .at_max(am_w9), .at_zero(az_w9));

   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_s9 (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]),
      .en(en), .up_dn(up_dn), .q(q_s9), .tc(tc_s9), .ovf(ovf_s9),
      .at_max(am_s9), .at_zero(az_s9));

   updown_mod_counter #(.WIDTH(8), .MAX_VAL(200), .SATURATE(0)) u_w200 (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .q(q_w200), .tc(tc_w200), .ovf(ovf_w200),
      .at_max(am_w200), .at_zero(az_w200));

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int i = 0; i < 3; i++) begin
         int lv;
         lv = int'(load_val) & m_mask[i];
         if (clr) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
         end else if (load) begin
            m_q[i] = (lv > m_max[i]) ? m_max[i] : lv;
            m_tc[i] = 0;
         end else if (en) begin
            int boundary;
            boundary = up_dn ? (m_q[i] == m_max[i]) : (m_q[i] == 0);
            m_tc[i] = boundary;
            if (boundary) begin
               m_ovf[i] = 1;
               if (m_sat[i] == 0) m_q[i] = up_dn ? 0 : m_max[i];
            end else begin
               m_q[i] = up_dn ? m_q[i] + 1 : m_q[i] - 1;
            end
         end else begin
            m_tc[i] = 0;
         end
      end
   endfunction

   task automatic check_all();
      check("w9.q",      int'(q_w9),    m_q[0]);
      check("w9.tc",     int'(tc_w9),   m_tc[0]);
      check("w9.ovf",    int'(ovf_w9),  m_ovf[0]);
      check("w9.at_max", int'(am_w9),   int'(m_q[0] == m_max[0]));
      check("w9.at_zero",int'(az_w9),   int'(m_q[0] == 0));
      check("s9.q",      int'(q_s9),    m_q[1]);
      check("s9.tc",     int'(tc_s9),   m_tc[1]);
      check("s9.ovf",    int'(ovf_s9),  m_ovf[1]);
      check("s9.at_max", int'(am_s9),   int'(m_q[1] == m_max[1]));
      check("s9.at_zero",int'(az_s9),   int'(m_q[1] == 0));
      check("w200.q",    int'(q_w200),  m_q[2]);
      check("w200.tc",   int'(tc_w200), m_tc[2]);
      check("w200.ovf",  int'(ovf_w200),m_ovf[2]);
      check("w200.at_max", int'(am_w200), int'(m_q[2] == m_max[2]));
      check("w200.at_zero",int'(az_w200), int'(m_q[2] == 0));
   endtask

   task automatic drive(input logic c, input logic l, input logic e,
                        input logic u, input logic [7:0] v);
      clr = c; load = l; en = e; up_dn = u; load_val = v;
   endtask

   // One clock: model advances on the same edge the DUT samples, checks #1 later.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
   task automatic async_reset_pulse();
      #3 reset = 1'b1;
      #1;
      model_reset();
      check("async.w9.q",   int'(q_w9),   0);
      check("async.w200.q", int'(q_w200), 0);
      check_all();
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic       clr, ld, en, up;
      logic [7:0] lv;
      int         eq, etc, eovf;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic c, input logic l, input logic e, input logic u,
                               input logic [7:0] v, input int q, input int t, input int o);
      vec_t r;
      r.clr = c; r.ld = l; r.en = e; r.up = u; r.lv = v;
      r.eq = q; r.etc = t; r.eovf = o;
      tbl.push_back(r);
   endfunction

   int sat_q[5]  = '{8, 9, 9, 9, 9};
   int sat_tc[5] = '{0, 0, 1, 1, 1};

   initial begin
      // Expected behaviour of the mod-10 wrap instance, starting from q=0, ovf=0.
      for (int k = 1; k <= 9; k++) add(0, 0, 1, 1, 8'd0, k, 0, 0);
      add(0, 0, 1, 1, 8'd0,   0, 1, 1);
      add(0, 0, 1, 1, 8'd0,   1, 0, 1);
      add(0, 1, 0, 0, 8'd2,   2, 0, 1);
      add(0, 0, 1, 0, 8'd0,   1, 0, 1);
      add(0, 0, 1, 0, 8'd0,   0, 0, 1);
      add(0, 0, 1, 0, 8'd0,   9, 1, 1);
      add(0, 0, 1, 0, 8'd0,   8, 0, 1);
      add(0, 1, 1, 1, 8'd250, 9, 0, 1);
      add(1, 1, 1, 1, 8'd250, 0, 0, 0);
      add(0, 1, 1, 1, 8'd17,  1, 0, 0);
      for (int k = 0; k < 10; k++) add(0, 0, 0, logic'(k % 2), 8'd0, 1, 0, 0);
      add(1, 0, 0, 0, 8'd0,   0, 0, 0);
      add(0, 0, 1, 0, 8'd0,   9, 1, 1);
      add(0, 0, 1, 0, 8'd0,   8, 0, 1);

      reset = 1'b1;
      drive(0, 0, 0, 0, 8'd0);
      model_reset();
      #19;
      check_all();
      reset = 1'b0;

      drive(0, 0, 1, 1, 8'd0);
      for (int k = 0; k < 5; k++) step();
      check("rst.count5", int'(q_w9), 5);
      check("rst.tc",     int'(tc_w9), 0);
      check("rst.ovf",    int'(ovf_w9), 0);
      async_reset_pulse();
      for (int k = 0; k < 3; k++) step();
      drive(1, 0, 0, 0, 8'd0);
      step();
      check("clr.q", int'(q_w200), 0);

      foreach (tbl[i]) begin
         drive(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].lv);
         step();
         check($sformatf("tbl%0d.q", i),   int'(q_w9),   tbl[i].eq);
         check($sformatf("tbl%0d.tc", i),  int'(tc_w9),  tbl[i].etc);
         check($sformatf("tbl%0d.ovf", i), int'(ovf_w9), tbl[i].eovf);
         if (tbl[i].ld && !tbl[i].clr && tbl[i].lv == 8'd250)
            check("w200.clamp", int'(q_w200), 200);
      end
      check("w200.wrapdown", int'(q_w200), 199);

      drive(0, 1, 0, 0, 8'd7);
      step();
      drive(0, 0, 1, 1, 8'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("sat%0d.q", k),  int'(q_s9),  sat_q[k]);
         check($sformatf("sat%0d.tc", k), int'(tc_s9), sat_tc[k]);
      end
      check("sat.ovf", int'(ovf_s9), 1);
      drive(0, 1, 0, 0, 8'd1);
      step();
      drive(0, 0, 1, 0, 8'd0);
      for (int k = 0; k < 3; k++) step();
      check("sat.down.q", int'(q_s9), 0);

      for (int n = 0; n < 800; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         drive(logic'(r < 3), logic'(r >= 3 && r < 12), logic'($urandom_range(0, 3) != 0),
               logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         step();
         if ($urandom_range(0, 79) == 0) async_reset_pulse();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
